// File: rtl/program_sequencer_if.sv
// ---------------------------------------------------------------------------
// program_sequencer_if
// Run-control bundle between the program sequencer and its surroundings:
// the harness start/done handshake, the fetched instruction, and the control
// outputs to the core's PC, register file and data memory.
//
// Signals
//   start        harness -> seq   launch request (active low after arming)
//   instr        core    -> seq   instruction fetched at the current PC
//   pc_load      seq     -> core  one-cycle PC load pulse
//   pc_load_addr seq     -> core  base address of the selected program
//   commit_en    seq     -> core  PC advance / RF / DMEM write enable
//   done         seq     -> harn  current program has halted
//   busy         seq     -> harn  a program is running
//   prog_idx     seq     -> harn  current / most recent program index
//   all_done     seq     -> harn  sticky: program 2 has halted since reset
//   cycle_count  seq     -> harn  committed cycles of the current program
//
// Modports: slave = the sequencer, master = harness/core side driving it.
// ---------------------------------------------------------------------------
interface program_sequencer_if #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9
);
  logic               start;
  logic [INSTR_W-1:0] instr;
  logic               pc_load;
  logic [PC_W-1:0]    pc_load_addr;
  logic               commit_en;
  logic               done;
  logic               busy;
  logic [1:0]         prog_idx;
  logic               all_done;
  logic [15:0]        cycle_count;

  modport slave (
    input  start, instr,
    output pc_load, pc_load_addr, commit_en, done, busy,
           prog_idx, all_done, cycle_count
  );

  modport master (
    output start, instr,
    input  pc_load, pc_load_addr, commit_en, done, busy,
           prog_idx, all_done, cycle_count
  );
endinterface

// File: rtl/program_sequencer.sv
// ---------------------------------------------------------------------------
// program_sequencer
// Run controller for the single-cycle core. Owns the start/done handshake
// with the test harness and runs three programs at fixed instruction-memory
// bases in rotation (0 -> 1 -> 2 -> 0). For each program it loads the PC,
// enables architectural commit while the program runs and stops on the halt
// instruction, which itself does not commit.
//
// Ports
//   clk    in   clock
//   reset  in   asynchronous, active-high reset
//   bus    slave modport of program_sequencer_if (see that file)
//
// Optional feature
//   PROG_SEQ_CYCLE_COUNT_EN  when defined, builds a 16-bit saturating counter
//                            of committed cycles, cleared at each launch.
//                            When undefined, cycle_count is tied to zero.
// ---------------------------------------------------------------------------
module program_sequencer #(
  parameter int                  PC_W       = 10,
  parameter int                  INSTR_W    = 9,
  parameter logic [INSTR_W-1:0]  HALT_INSTR = 9'b010000000,
  parameter logic [PC_W-1:0]     PROG0_BASE = 10'd0,
  parameter logic [PC_W-1:0]     PROG1_BASE = 10'd256,
  parameter logic [PC_W-1:0]     PROG2_BASE = 10'd512
) (
  input  logic                  clk,
  input  logic                  reset,
  program_sequencer_if.slave    bus
);

  localparam logic [1:0] ST_ARMED  = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  logic [1:0] state_q,    state_d;
  logic [1:0] prog_idx_q, prog_idx_d;
  logic       all_done_q, all_done_d;
  logic       is_halt;

  assign is_halt = (bus.instr == HALT_INSTR);

  // NOTE: every variable assigned in an always_comb gets a default at the top
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    prog_idx_d = prog_idx_q;
    all_done_d = all_done_q;
    case (state_q)
      ST_ARMED:  if (!bus.start) state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_RUN;
      ST_RUN: begin
        if (is_halt) begin
          state_d = ST_HALTED;
          if (prog_idx_q == 2'd2) all_done_d = 1'b1;
        end
      end
      ST_HALTED: begin
        // Acknowledge: release done and rotate to the next program.
        if (bus.start) begin
          state_d    = ST_ARMED;
          prog_idx_d = (prog_idx_q == 2'd2) ? 2'd0 : prog_idx_q + 2'd1;
        end
      end
      default: state_d = ST_ARMED;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_ARMED;
      prog_idx_q <= 2'd0;
      all_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prog_idx_q <= prog_idx_d;
      all_done_q <= all_done_d;
    end
  end

  // Outputs decode the state register directly; only commit_en also looks
  // at the live instruction so the halt cycle never commits.
  assign bus.pc_load   = (state_q == ST_LAUNCH);
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_HALTED);
  assign bus.commit_en = (state_q == ST_RUN) && !is_halt;
  assign bus.prog_idx  = prog_idx_q;
  assign bus.all_done  = all_done_q;

  always_comb begin
    case (prog_idx_q)
      2'd1:    bus.pc_load_addr = PROG1_BASE;
      2'd2:    bus.pc_load_addr = PROG2_BASE;
      default: bus.pc_load_addr = PROG0_BASE;
    endcase
  end

`ifdef PROG_SEQ_CYCLE_COUNT_EN
  logic [15:0] cycle_count_q, cycle_count_d;

  always_comb begin
    cycle_count_d = cycle_count_q;
    if (state_q == ST_LAUNCH)
      cycle_count_d = 16'd0;
    else if (bus.commit_en && (cycle_count_q != 16'hFFFF))
      cycle_count_d = cycle_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cycle_count_q <= 16'd0;
    else       cycle_count_q <= cycle_count_d;
  end

  assign bus.cycle_count = cycle_count_q;
`else
  assign bus.cycle_count = 16'd0;
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// ---------------------------------------------------------------------------
// tb_program_sequencer
// Directed, table-driven bench for program_sequencer. Each table row is one
// clock cycle: inputs applied shortly after the rising edge, outputs compared
// mid-cycle. Rows walk programs 0 (5 commits + halt), 1 (halt first),
// 2 (2 commits + halt), wrap to 0, then 1 and into 2. Hand-written sequences
// cover reset assertion mid-RUN and start already low when reset releases.
// ---------------------------------------------------------------------------
module tb_program_sequencer;

  localparam logic [8:0] NOP  = 9'h001;
  localparam logic [8:0] HALT = 9'b010000000;
`ifdef PROG_SEQ_CYCLE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk;
  logic reset;

  program_sequencer_if #(.PC_W(10), .INSTR_W(9)) sif ();

  program_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [8:0] instr;
    logic       pc_load;
    logic       commit;
    logic       done;
    logic       busy;
    logic [1:0] idx;
    logic       all_done;
    logic [9:0] addr;
    logic [15:0] cnt;
  } vec_t;

  vec_t vq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic pl, input logic ce,
                           input logic dn, input logic bz, input logic [1:0] idx,
                           input logic ad, input logic [9:0] addr, input logic [15:0] cnt);
    check({tag, ".pc_load"},      32'(sif.pc_load),      32'(pl));
    check({tag, ".commit_en"},    32'(sif.commit_en),    32'(ce));
    check({tag, ".done"},         32'(sif.done),         32'(dn));
    check({tag, ".busy"},         32'(sif.busy),         32'(bz));
    check({tag, ".prog_idx"},     32'(sif.prog_idx),     32'(idx));
    check({tag, ".all_done"},     32'(sif.all_done),     32'(ad));
    check({tag, ".pc_load_addr"}, 32'(sif.pc_load_addr), 32'(addr));
    check({tag, ".cycle_count"},  32'(sif.cycle_count),  CNT_EN ? 32'(cnt) : 32'd0);
  endtask

  task automatic add(input logic st, input logic [8:0] in, input logic pl,
                     input logic ce, input logic dn, input logic bz,
                     input logic [1:0] idx, input logic ad, input logic [9:0] addr,
                     input logic [15:0] cnt);
    vec_t v;
    v.start = st;  v.instr = in;  v.pc_load = pl; v.commit = ce;
    v.done = dn;   v.busy = bz;   v.idx = idx;    v.all_done = ad;
    v.addr = addr; v.cnt = cnt;
    vq.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //  start instr pl ce dn bz idx ad addr cnt
    // Program 0: arm, launch, 5 commits, halt, wait, acknowledge.
    add(1, NOP,  0, 0, 0, 0, 0, 0,   0, 0);   // 0  ARMED
    add(1, NOP,  0, 0, 0, 0, 0, 0,   0, 0);   // 1  ARMED
    add(0, NOP,  0, 0, 0, 0, 0, 0,   0, 0);   // 2  ARMED, start sampled low
    add(0, NOP,  1, 0, 0, 0, 0, 0,   0, 0);   // 3  LAUNCH
    add(0, NOP,  0, 1, 0, 1, 0, 0,   0, 0);   // 4  RUN
    add(0, NOP,  0, 1, 0, 1, 0, 0,   0, 1);
    add(0, NOP,  0, 1, 0, 1, 0, 0,   0, 2);
    add(0, NOP,  0, 1, 0, 1, 0, 0,   0, 3);
    add(0, NOP,  0, 1, 0, 1, 0, 0,   0, 4);   // 8  fifth commit
    add(0, HALT, 0, 0, 0, 1, 0, 0,   0, 5);   // 9  halt does not commit
    add(0, NOP,  0, 0, 1, 0, 0, 0,   0, 5);   // 10 HALTED, start low: hold
    add(1, NOP,  0, 0, 1, 0, 0, 0,   0, 5);   // 11 start high sampled
    add(1, NOP,  0, 0, 0, 0, 1, 0, 256, 5);   // 12 ARMED, idx 1, count held
    add(0, NOP,  0, 0, 0, 0, 1, 0, 256, 5);   // 13
    add(0, NOP,  1, 0, 0, 0, 1, 0, 256, 5);   // 14 LAUNCH prog 1
    // Program 1: halt as the first instruction.
    add(0, HALT, 0, 0, 0, 1, 1, 0, 256, 0);   // 15
    add(0, NOP,  0, 0, 1, 0, 1, 0, 256, 0);   // 16 done two cycles after pc_load
    add(1, NOP,  0, 0, 1, 0, 1, 0, 256, 0);   // 17
    add(0, NOP,  0, 0, 0, 0, 2, 0, 512, 0);   // 18 ARMED idx 2
    add(0, NOP,  1, 0, 0, 0, 2, 0, 512, 0);   // 19 LAUNCH prog 2
    add(0, NOP,  0, 1, 0, 1, 2, 0, 512, 0);   // 20
    add(0, NOP,  0, 1, 0, 1, 2, 0, 512, 1);   // 21
    add(0, HALT, 0, 0, 0, 1, 2, 0, 512, 2);   // 22
    add(0, NOP,  0, 0, 1, 0, 2, 1, 512, 2);   // 23 all_done sets with done
    add(1, NOP,  0, 0, 1, 0, 2, 1, 512, 2);   // 24
    add(1, NOP,  0, 0, 0, 0, 0, 1,   0, 2);   // 25 wrap to 0, all_done sticky
    add(0, NOP,  0, 0, 0, 0, 0, 1,   0, 2);   // 26
    add(0, NOP,  1, 0, 0, 0, 0, 1,   0, 2);   // 27 LAUNCH prog 0 again
    add(1, NOP,  0, 1, 0, 1, 0, 1,   0, 0);   // 28 start high in RUN ignored
    add(0, NOP,  0, 1, 0, 1, 0, 1,   0, 1);   // 29
    add(0, HALT, 0, 0, 0, 1, 0, 1,   0, 2);   // 30
    add(0, NOP,  0, 0, 1, 0, 0, 1,   0, 2);   // 31
    add(1, NOP,  0, 0, 1, 0, 0, 1,   0, 2);   // 32
    add(0, NOP,  0, 0, 0, 0, 1, 1, 256, 2);   // 33
    add(0, NOP,  1, 0, 0, 0, 1, 1, 256, 2);   // 34
    add(0, HALT, 0, 0, 0, 1, 1, 1, 256, 0);   // 35
    add(1, NOP,  0, 0, 1, 0, 1, 1, 256, 0);   // 36
    add(0, NOP,  0, 0, 0, 0, 2, 1, 512, 0);   // 37
    add(0, NOP,  1, 0, 0, 0, 2, 1, 512, 0);   // 38
    add(0, NOP,  0, 1, 0, 1, 2, 1, 512, 0);   // 39 RUN prog 2

    // Reset state, checked while reset is held.
    reset     = 1'b1;
    sif.start = 1'b1;
    sif.instr = NOP;
    repeat (2) @(posedge clk);
    #2;
    check_all("reset", 0, 0, 0, 0, 2'd0, 0, 10'd0, 16'd0);
    reset = 1'b0;

    foreach (vq[i]) begin
      @(posedge clk);
      #2;
      sif.start = vq[i].start;
      sif.instr = vq[i].instr;
      #2;
      check_all($sformatf("row%0d", i), vq[i].pc_load, vq[i].commit, vq[i].done,
                vq[i].busy, vq[i].idx, vq[i].all_done, vq[i].addr, vq[i].cnt);
    end

    // Reset asserted mid-RUN of program 2: commit_en drops without a clock.
    @(posedge clk);
    #2;
    sif.start = 1'b0;
    sif.instr = NOP;
    #1;
    check_all("pre_reset", 0, 1, 0, 1, 2'd2, 1, 10'd512, 16'd1);
    reset = 1'b1;
    #1;
    check_all("mid_run_reset", 0, 0, 0, 0, 2'd0, 0, 10'd0, 16'd0);

    // start already low when reset releases: launch at the first edge.
    @(posedge clk);
    #2;
    reset = 1'b0;
    #2;
    check_all("post_release", 0, 0, 0, 0, 2'd0, 0, 10'd0, 16'd0);
    @(posedge clk);
    #2;
    check_all("early_launch", 1, 0, 0, 0, 2'd0, 0, 10'd0, 16'd0);
    @(posedge clk);
    #2;
    check_all("early_run", 0, 1, 0, 1, 2'd0, 0, 10'd0, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
